// File: rtl/goal_event_gen.sv
// Goal detector and match scorekeeper for a two-player ball game, sampled once per video frame.
// Optional macro GOAL_CONFIRM_EN: a goal must be seen on two consecutive frames before it scores.
module goal_event_gen #(
    parameter logic [10:0] GOAL1_X_MAX     = 11'd40,
    parameter logic [10:0] GOAL2_X_MIN     = 11'd600,
    parameter logic [10:0] GOAL_Y_MIN      = 11'd180,
    parameter logic [10:0] GOAL_Y_MAX      = 11'd300,
    parameter logic [3:0]  WIN_SCORE       = 4'd5,
    parameter logic [7:0]  COOLDOWN_FRAMES = 8'd60
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] ballX,
    input  logic [10:0] ballY,
    input  logic        newGame,
    output logic [1:0]  scoreEvent,
    output logic [3:0]  digitP1,
    output logic [3:0]  digitP2,
    output logic        gameOver,
    output logic        winner
);

`ifdef GOAL_CONFIRM_EN
    typedef enum logic [1:0] {PLAY = 2'd0, CONFIRM = 2'd1, COOLDOWN = 2'd2, GAME_OVER = 2'd3} state_t;
`else
    typedef enum logic [1:0] {PLAY = 2'd0, COOLDOWN = 2'd2, GAME_OVER = 2'd3} state_t;
`endif

    state_t     state;
    logic [7:0] cnt;
    logic       in_y;
    logic       in_right;
    logic       in_left;
    logic [1:0] goal_side;
    logic [1:0] fire;
    logic [3:0] p1_inc;
    logic [3:0] p2_inc;
    logic       win_hit;
`ifdef GOAL_CONFIRM_EN
    logic [1:0] pend_side;
`endif

    // Player1 wins ties: a ball in the right mouth is checked first.
    always_comb begin
        in_y      = (ballY >= GOAL_Y_MIN) && (ballY <= GOAL_Y_MAX);
        in_right  = (ballX >= GOAL2_X_MIN) && in_y;
        in_left   = (ballX <= GOAL1_X_MAX) && in_y;
        goal_side = in_right ? 2'b01 : (in_left ? 2'b10 : 2'b00);
    end

    always_comb begin
        fire = 2'b00;
`ifdef GOAL_CONFIRM_EN
        if (startOfFrame && state == CONFIRM && goal_side == pend_side)
            fire = goal_side;
`else
        if (startOfFrame && state == PLAY)
            fire = goal_side;
`endif
    end

    always_comb begin
        p1_inc  = (digitP1 >= 4'd9) ? 4'd9 : digitP1 + 4'd1;
        p2_inc  = (digitP2 >= 4'd9) ? 4'd9 : digitP2 + 4'd1;
        win_hit = fire[0] ? (p1_inc == WIN_SCORE) : (p2_inc == WIN_SCORE);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= PLAY;
            scoreEvent <= 2'b00;
            digitP1    <= 4'd0;
            digitP2    <= 4'd0;
            gameOver   <= 1'b0;
            winner     <= 1'b0;
            cnt        <= 8'd0;
`ifdef GOAL_CONFIRM_EN
            pend_side  <= 2'b00;
`endif
        end else begin
            scoreEvent <= 2'b00;
            if (newGame) begin
                state    <= PLAY;
                digitP1  <= 4'd0;
                digitP2  <= 4'd0;
                gameOver <= 1'b0;
                winner   <= 1'b0;
                cnt      <= 8'd0;
`ifdef GOAL_CONFIRM_EN
                pend_side <= 2'b00;
`endif
            end else if (fire != 2'b00) begin
                scoreEvent <= fire;
                if (fire[0]) digitP1 <= p1_inc;
                else         digitP2 <= p2_inc;
                if (win_hit) begin
                    state    <= GAME_OVER;
                    gameOver <= 1'b1;
                    winner   <= fire[1];
                end else begin
                    state <= COOLDOWN;
                    cnt   <= COOLDOWN_FRAMES;
                end
`ifdef GOAL_CONFIRM_EN
                pend_side <= 2'b00;
`endif
            end else if (startOfFrame) begin
                case (state)
`ifdef GOAL_CONFIRM_EN
                    PLAY: begin
                        if (goal_side != 2'b00) begin
                            state     <= CONFIRM;
                            pend_side <= goal_side;
                        end
                    end
                    CONFIRM: begin
                        state     <= PLAY;
                        pend_side <= 2'b00;
                    end
`endif
                    // Hold off until the timer expires and the ball has left both mouths.
                    COOLDOWN: begin
                        if (cnt != 8'd0)
                            cnt <= cnt - 8'd1;
                        else if (goal_side == 2'b00)
                            state <= PLAY;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
